sd_bit_serializer: RTL

SD_BIT_SERIALIZER -- requirements
Module: sd_bit_serializer

---
 rtl/sd_bit_serializer.sv | 108 ++++++++++
 1 files changed

// File: rtl/sd_bit_serializer.sv
// Parallel-to-serial converter with a one-word holding register so that
// back-to-back words stream out without a gap between them.
module sd_bit_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             dout_bit,
  output logic             bit_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic {StIdle, StShift} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             full_q, full_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic             accept;
  logic             out_end;
  logic [WIDTH-1:0] shift_adv;

  assign data_ready = ~full_q & ~flush;
  assign accept     = data_valid & data_ready;

  // Advance moves the next bit into the output end of the register.
  assign shift_adv = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0} : {1'b0, shift_q[WIDTH-1:1]};
  assign out_end   = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    hold_d  = hold_q;
    full_d  = full_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          shift_d = data_in;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        if (cnt_q != CntLast) begin
          shift_d = shift_adv;
          cnt_d   = cnt_q + 1'b1;
          if (accept) begin
            hold_d = data_in;
            full_d = 1'b1;
          end
        end else if (full_q) begin
          shift_d = hold_q;
          full_d  = 1'b0;
          cnt_d   = '0;
        end else if (accept) begin
          shift_d = data_in;
          cnt_d   = '0;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (flush) begin
      state_d = StIdle;
      full_d  = 1'b0;
      cnt_d   = '0;
      shift_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      shift_q <= '0;
      hold_q  <= '0;
      full_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      hold_q  <= hold_d;
      full_q  <= full_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bit_valid = (state_q == StShift);
  assign dout_bit  = bit_valid ? out_end : IDLE_BIT;
  assign word_done = bit_valid && (cnt_q == CntLast);
  assign busy      = bit_valid | full_q;

endmodule
